// File: rtl/game_pkg.sv
// Shared types, widths and helpers for the reaction-game light logic.
package game_pkg;

   localparam int NUM_LEDS_DEF = 7;
   localparam int DIFF_W       = 7;
   localparam int LVL_W        = 3;
   localparam int POS_W        = 3;
   localparam int CNT_W        = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Level is one past the highest set switch, so higher switches always win.
   function automatic logic [LVL_W-1:0] level_of(input logic [DIFF_W-1:0] d);
      logic [LVL_W-1:0] l;
      l = '0;
      for (int i = 0; i < DIFF_W; i++) begin
         if (d[i]) l = LVL_W'(i + 1);
      end
      return l;
   endfunction

   function automatic logic [CNT_W-1:0] period_of(input int unsigned base,
                                                  input logic [LVL_W-1:0] lvl);
      logic [CNT_W-1:0] p;
      p = CNT_W'(base) >> lvl;
      if (p == '0) p = CNT_W'(1);
      return p;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running cycle divider: pulses tick on the last cycle of each period.
module tick_divider
   import game_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         run,
   input  logic [W-1:0] period,
   output logic         tick
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // >= rather than == keeps the counter bounded if period ever shrinks mid-count.
   assign tick = run && !clear && (count_q >= period - W'(1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run) begin
         count_d = tick ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/light_sequencer.sv
// Ping-pong single-LED sweep for the reaction game, with difficulty-scaled
// speed and a timed freeze after a hit.
module light_sequencer
   import game_pkg::*;
#(
   parameter int NUM_LEDS    = NUM_LEDS_DEF,
   parameter int BASE_DIV    = 2500000,
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [DIFF_W-1:0]   diff,
   input  logic                freeze,
   output logic [NUM_LEDS-1:0] led,
   output logic [POS_W-1:0]    pos,
   output logic                at_target,
   output logic                step,
   output logic                holding
);

   localparam logic [POS_W-1:0] POS_TURN = POS_W'(NUM_LEDS - 2);

   state_e                state_q, state_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic                  dir_up_q, dir_up_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [NUM_LEDS-1:0]   led_q, led_d;
   logic                  at_target_q, at_target_d;
   logic                  holding_q, holding_d;
   logic                  step_q, step_d;

   logic [CNT_W-1:0]      step_period;
   logic                  step_tick;
   logic                  hold_tick;

   assign step_period = period_of(BASE_DIV, level_q);

   // Leaving RUN clears the step divider, so every resume waits a full period.
   tick_divider #(.W(CNT_W)) u_step_div (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q != ST_RUN),
      .run    (state_q == ST_RUN),
      .period (step_period),
      .tick   (step_tick)
   );

   tick_divider #(.W(CNT_W)) u_hold_div (
      .clk    (clk),
      .reset  (reset),
      .clear  ((state_q != ST_HOLD) || !enable),
      .run    (state_q == ST_HOLD),
      .period (CNT_W'(HOLD_CYCLES)),
      .tick   (hold_tick)
   );

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      dir_up_d = dir_up_q;
      level_d  = level_q;
      step_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d  = ST_RUN;
               pos_d    = '0;
               dir_up_d = 1'b1;
               level_d  = level_of(diff);
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               if (step_tick) begin
                  step_d = 1'b1;
                  if (dir_up_q) begin
                     pos_d = pos_q + POS_W'(1);
                     if (pos_q == POS_TURN) dir_up_d = 1'b0;
                  end else begin
                     pos_d = pos_q - POS_W'(1);
                     // Speed changes only when the sweep lands on the target.
                     if (pos_q == POS_W'(1)) begin
                        dir_up_d = 1'b1;
                        level_d  = level_of(diff);
                     end
                  end
               end
               if (freeze) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (hold_tick) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) begin
         pos_d    = '0;
         dir_up_d = 1'b1;
         step_d   = 1'b0;
      end

      led_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         led_d[i] = (state_d != ST_IDLE) && (pos_d == POS_W'(i));
      end
      at_target_d = (state_d != ST_IDLE) && (pos_d == '0);
      holding_d   = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pos_q       <= '0;
         dir_up_q    <= 1'b1;
         level_q     <= '0;
         led_q       <= '0;
         at_target_q <= 1'b0;
         holding_q   <= 1'b0;
         step_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         dir_up_q    <= dir_up_d;
         level_q     <= level_d;
         led_q       <= led_d;
         at_target_q <= at_target_d;
         holding_q   <= holding_d;
         step_q      <= step_d;
      end
   end

   assign led       = led_q;
   assign pos       = pos_q;
   assign at_target = at_target_q;
   assign holding   = holding_q;
   assign step      = step_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: per-cycle model compare plus literal checkpoints.
module tb_light_sequencer;

   localparam int N    = 7;
   localparam int BASE = 64;
   localparam int HOLD = 20;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         freeze;
   logic [6:0]   diff;
   logic [N-1:0] led;
   logic [2:0]   pos;
   logic         at_target;
   logic         step;
   logic         holding;

   always #5 clk = ~clk;

   light_sequencer #(
      .NUM_LEDS    (N),
      .BASE_DIV    (BASE),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .diff      (diff),
      .freeze    (freeze),
      .led       (led),
      .pos       (pos),
      .at_target (at_target),
      .step      (step),
      .holding   (holding)
   );

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   // Model: mode 0 idle, 1 run, 2 hold; position is a triangle wave of the step count.
   int m_mode    = 0;
   int m_k       = 0;
   int m_period  = BASE;
   int m_elapsed = 0;
   int m_hold_el = 0;
   bit m_step    = 1'b0;

   function automatic int pp(input int k);
      int r;
      r = k % (2 * (N - 1));
      return (r <= N - 1) ? r : 2 * (N - 1) - r;
   endfunction

   function automatic int period_for(input logic [6:0] d);
      int lvl;
      int p;
      lvl = 0;
      for (int v = int'(d); v > 0; v = v >> 1) lvl++;
      p = BASE >> lvl;
      return (p < 1) ? 1 : p;
   endfunction

   task automatic model_edge();
      m_step = 1'b0;
      if (reset) begin
         m_mode = 0; m_k = 0; m_elapsed = 0; m_hold_el = 0; m_period = BASE;
      end else if (m_mode == 0) begin
         if (enable) begin
            m_mode = 1; m_k = 0; m_elapsed = 0; m_period = period_for(diff);
         end
      end else if (!enable) begin
         m_mode = 0;
      end else if (m_mode == 1) begin
         m_elapsed++;
         if (m_elapsed == m_period) begin
            m_step = 1'b1;
            m_k++;
            m_elapsed = 0;
            if (pp(m_k) == 0) m_period = period_for(diff);
         end
         if (freeze) begin
            m_mode = 2; m_hold_el = 0;
         end
      end else begin
         m_hold_el++;
         if (m_hold_el == HOLD) begin
            m_mode = 1; m_elapsed = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   initial forever begin
      logic [N-1:0] e_led;
      logic [2:0]   e_pos;
      logic         e_tgt;
      logic         e_hold;
      logic         e_step;
      @(negedge clk);
      if (check_en) begin
         e_pos  = (m_mode == 0) ? 3'd0 : 3'(pp(m_k));
         e_led  = (m_mode == 0) ? '0 : (N'(1) << pp(m_k));
         e_tgt  = (m_mode != 0) && (e_pos == 3'd0);
         e_hold = (m_mode == 2);
         e_step = m_step && (m_mode != 0);
         vectors++;
         if (led !== e_led || pos !== e_pos || at_target !== e_tgt ||
             holding !== e_hold || step !== e_step) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t led=%b want %b pos=%0d want %0d tgt=%b want %b step=%b want %b hold=%b want %b",
                     $time, led, e_led, pos, e_pos, at_target, e_tgt, step, e_step, holding, e_hold);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_step_to(input int p, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (m_step && m_mode != 0 && pp(m_k) == p) hit = 1'b1;
      end
      if (!hit) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_step_to timeout model_pos=%0d want %0d", pp(m_k), p);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t got running want finished", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; freeze = 1'b0; diff = 7'd0;
      cyc(3);
      check_en = 1'b1;
      chk("reset_led", 32'(led), 0);
      chk("reset_pos", 32'(pos), 0);
      reset = 1'b0;
      cyc(1);

      // Slowest speed: first step exactly 64 cycles after entering RUN.
      enable = 1'b1;
      cyc(1);
      chk("enable_led", 32'(led), 1);
      chk("enable_target", 32'(at_target), 1);
      cyc(63);
      chk("first_step_early", 32'(pos), 0);
      cyc(1);
      chk("first_step_pos", 32'(pos), 1);
      chk("first_step_pulse", 32'(step), 1);
      chk("first_step_target", 32'(at_target), 0);

      // Freeze at pos 2, with a second freeze ignored mid-hold.
      wait_step_to(2, 200);
      cyc(5);
      freeze = 1'b1;
      cyc(1);
      freeze = 1'b0;
      chk("hold_start", 32'(holding), 1);
      chk("hold_pos", 32'(pos), 2);
      cyc(4);
      freeze = 1'b1;
      cyc(1);
      freeze = 1'b0;
      cyc(14);
      chk("hold_last", 32'(holding), 1);
      chk("hold_last_pos", 32'(pos), 2);
      cyc(1);
      chk("hold_end", 32'(holding), 0);
      cyc(63);
      chk("resume_early", 32'(pos), 2);
      cyc(1);
      chk("resume_step", 32'(pos), 3);

      // Faster difficulty applies only after the sweep returns to pos 0.
      diff = 7'b0000100;
      cyc(63);
      chk("no_midsweep_speed", 32'(pos), 3);
      cyc(1);
      chk("still_slow_step", 32'(pos), 4);
      wait_step_to(0, 1000);
      chk("back_at_target", 32'(at_target), 1);
      cyc(7);
      chk("fast_early", 32'(pos), 0);
      cyc(1);
      chk("fast_step", 32'(pos), 1);

      // Freeze coinciding with the 5->6 step.
      wait_step_to(5, 200);
      cyc(7);
      freeze = 1'b1;
      cyc(1);
      freeze = 1'b0;
      chk("coincide_pos", 32'(pos), 6);
      chk("coincide_hold", 32'(holding), 1);
      chk("coincide_step", 32'(step), 1);

      // Disable together with freeze wins.
      cyc(25);
      enable = 1'b0;
      freeze = 1'b1;
      cyc(1);
      freeze = 1'b0;
      chk("disable_hold", 32'(holding), 0);
      chk("disable_led", 32'(led), 0);
      chk("disable_pos", 32'(pos), 0);

      // Max difficulty: period clamps to one cycle.
      diff = 7'b1111111;
      cyc(1);
      enable = 1'b1;
      cyc(1);
      chk("max_start", 32'(pos), 0);
      cyc(1);
      chk("max_pos1", 32'(pos), 1);
      cyc(5);
      chk("max_pos6", 32'(led), 32'h40);
      cyc(1);
      chk("max_bounce", 32'(pos), 5);
      cyc(1);
      chk("max_pos4", 32'(pos), 4);

      // Reset mid-run.
      reset = 1'b1;
      cyc(1);
      chk("midrun_reset_led", 32'(led), 0);
      chk("midrun_reset_pos", 32'(pos), 0);
      chk("midrun_reset_step", 32'(step), 0);
      chk("midrun_reset_hold", 32'(holding), 0);
      reset = 1'b0;
      enable = 1'b0;
      cyc(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
